fetch_issue: RTL and testbench

//  Fetch-side producer for the instruction buffer: generates the PC stream, drives the ICache

---
 rtl/fetch_issue_pkg.sv | 30 +++
 rtl/fetch_issue_skid.sv | 51 +++++
 rtl/fetch_issue.sv | 170 +++++++++++++++++
 tb/tb_fetch_issue.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_issue_pkg.sv
// rtl/fetch_issue_pkg.sv - shared state encodings, defaults and packet layout for fetch_issue
package fetch_issue_pkg;

  localparam int PC_W    = 32;
  localparam int INST_W  = 32;
  localparam int PRED_W  = 32;
  localparam int EXC_W   = 1;
  localparam int CAUSE_W = 7;

  localparam logic [PC_W-1:0]    DEF_RESET_PC   = 32'h1c00_0000;
  localparam logic [CAUSE_W-1:0] DEF_ECODE_ADEF = 7'h08;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_EXC  = 3'd4
  } state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc1;
    logic [PC_W-1:0]   pc2;
    logic [INST_W-1:0] inst1;
    logic [INST_W-1:0] inst2;
    logic [PRED_W-1:0] pred;
    logic [EXC_W-1:0]  exc;
  } pkt_t;

endpackage

// File: rtl/fetch_issue_skid.sv
// rtl/fetch_issue_skid.sv - one-entry holding register for a response that met a stalled buffer
module fetch_issue_skid
  import fetch_issue_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [INST_W-1:0] inst1_i,
  input  logic [INST_W-1:0] inst2_i,
  input  logic [PRED_W-1:0] pred_i,
  output logic              valid_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst1_o,
  output logic [INST_W-1:0] inst2_o,
  output logic [PRED_W-1:0] pred_o
);

  logic              valid_q;
  logic [PC_W-1:0]   pc_q;
  logic [INST_W-1:0] inst1_q;
  logic [INST_W-1:0] inst2_q;
  logic [PRED_W-1:0] pred_q;

  // Clear wins over load so a flush in the same cycle leaves the entry empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst1_q <= '0;
      inst2_q <= '0;
      pred_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      inst1_q <= inst1_i;
      inst2_q <= inst2_i;
      pred_q  <= pred_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst1_o = inst1_q;
  assign inst2_o = inst2_q;
  assign pred_o  = pred_q;

endmodule

// File: rtl/fetch_issue.sv
// rtl/fetch_issue.sv - PC generation, ICache handshake and packet push into the instruction buffer
// BPRED_EN: when defined, bp_taken/bp_target steer the next fetch PC.
module fetch_issue
  import fetch_issue_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC   = DEF_RESET_PC,
  parameter logic [CAUSE_W-1:0] ECODE_ADEF = DEF_ECODE_ADEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [PC_W-1:0]    flush_pc,
  input  logic               stall,
  output logic               icache_req,
  output logic [PC_W-1:0]    icache_addr,
  input  logic               icache_ready,
  input  logic               icache_rvalid,
  input  logic [INST_W-1:0]  icache_rdata1,
  input  logic [INST_W-1:0]  icache_rdata2,
`ifdef BPRED_EN
  input  logic               bp_taken,
  input  logic [PC_W-1:0]    bp_target,
`endif
  output logic               inst_valid,
  output logic [PC_W-1:0]    pc1,
  output logic [PC_W-1:0]    pc2,
  output logic [INST_W-1:0]  inst1,
  output logic [INST_W-1:0]  inst2,
  output logic [PRED_W-1:0]  pred_addr,
  output logic               is_exception,
  output logic [CAUSE_W-1:0] exception_cause
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              drop_q, drop_d;
  logic              valid_q, valid_d;
  pkt_t              pkt_q, pkt_d;

  logic              skid_load, skid_clear, skid_valid;
  logic [PC_W-1:0]   skid_pc;
  logic [INST_W-1:0] skid_inst1, skid_inst2;
  logic [PRED_W-1:0] skid_pred;

  logic              misaligned;
  logic              req_ok;
  logic [PC_W-1:0]   seq_pc;
  logic [PC_W-1:0]   rsp_next_pc;

  assign misaligned = |pc_q[1:0];
  // A request may only go out once any discarded response has come back.
  assign req_ok     = (state_q == ST_REQ) && !drop_q && !misaligned;
  assign seq_pc     = pc_q + 32'd8;

`ifdef BPRED_EN
  assign rsp_next_pc = bp_taken ? bp_target : seq_pc;
`else
  assign rsp_next_pc = seq_pc;
`endif

  assign icache_req  = req_ok;
  assign icache_addr = req_ok ? pc_q : '0;

  fetch_issue_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .pc_i    (pc_q),
    .inst1_i (icache_rdata1),
    .inst2_i (icache_rdata2),
    .pred_i  (rsp_next_pc),
    .valid_o (skid_valid),
    .pc_o    (skid_pc),
    .inst1_o (skid_inst1),
    .inst2_o (skid_inst2),
    .pred_o  (skid_pred)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q && !icache_rvalid;
    valid_d    = 1'b0;
    pkt_d      = pkt_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (misaligned) begin
          if (!stall) begin
            valid_d = 1'b1;
            pkt_d   = '{pc1: pc_q, pc2: pc_q + 32'd4, inst1: '0, inst2: '0,
                        pred: seq_pc, exc: 1'b1};
            state_d = ST_EXC;
          end
        end else if (req_ok && icache_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (icache_rvalid) begin
          if (stall) begin
            skid_load = 1'b1;
            state_d   = ST_HOLD;
          end else begin
            valid_d = 1'b1;
            pkt_d   = '{pc1: pc_q, pc2: pc_q + 32'd4, inst1: icache_rdata1,
                        inst2: icache_rdata2, pred: rsp_next_pc, exc: 1'b0};
            pc_d    = rsp_next_pc;
            state_d = ST_REQ;
          end
        end
      end
      ST_HOLD: begin
        if (!stall && skid_valid) begin
          valid_d    = 1'b1;
          pkt_d      = '{pc1: skid_pc, pc2: skid_pc + 32'd4, inst1: skid_inst1,
                         inst2: skid_inst2, pred: skid_pred, exc: 1'b0};
          pc_d       = skid_pred;
          skid_clear = 1'b1;
          state_d    = ST_REQ;
        end
      end
      ST_EXC: state_d = ST_EXC;
      default: state_d = ST_IDLE;
    endcase

    // A response arriving with the flush is consumed here, so only mark drop when one is still owed.
    if (flush) begin
      valid_d    = 1'b0;
      pkt_d      = pkt_q;
      skid_load  = 1'b0;
      skid_clear = 1'b1;
      pc_d       = flush_pc;
      state_d    = ST_REQ;
      if ((state_q == ST_WAIT && !icache_rvalid) || (req_ok && icache_ready)) begin
        drop_d = 1'b1;
      end
    end
  end

  assign inst_valid      = valid_q;
  assign pc1             = pkt_q.pc1;
  assign pc2             = pkt_q.pc2;
  assign inst1           = pkt_q.inst1;
  assign inst2           = pkt_q.inst2;
  assign pred_addr       = pkt_q.pred;
  assign is_exception    = pkt_q.exc[0];
  assign exception_cause = pkt_q.exc[0] ? ECODE_ADEF : '0;

endmodule

// File: tb/tb_fetch_issue.sv
// tb/tb_fetch_issue.sv - directed self-checking bench for fetch_issue
module tb_fetch_issue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] flush_pc;
  logic        stall;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_ready;
  logic        icache_rvalid;
  logic [31:0] icache_rdata1;
  logic [31:0] icache_rdata2;
`ifdef BPRED_EN
  logic        bp_taken;
  logic [31:0] bp_target;
`endif
  logic        inst_valid;
  logic [31:0] pc1, pc2, inst1, inst2, pred_addr;
  logic        is_exception;
  logic [6:0]  exception_cause;

  int tests = 0;
  int fails = 0;

  fetch_issue dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .flush_pc        (flush_pc),
    .stall           (stall),
    .icache_req      (icache_req),
    .icache_addr     (icache_addr),
    .icache_ready    (icache_ready),
    .icache_rvalid   (icache_rvalid),
    .icache_rdata1   (icache_rdata1),
    .icache_rdata2   (icache_rdata2),
`ifdef BPRED_EN
    .bp_taken        (bp_taken),
    .bp_target       (bp_target),
`endif
    .inst_valid      (inst_valid),
    .pc1             (pc1),
    .pc2             (pc2),
    .inst1           (inst1),
    .inst2           (inst2),
    .pred_addr       (pred_addr),
    .is_exception    (is_exception),
    .exception_cause (exception_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, check its address and accept it.
  task automatic accept_req(input string tag, input logic [31:0] exp_addr);
    int n = 0;
    while (!icache_req && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_req"}, {31'd0, icache_req}, 32'd1);
    chk({tag, "_addr"}, icache_addr, exp_addr);
    icache_ready = 1'b1;
    step();
    icache_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d1, input logic [31:0] d2);
    icache_rvalid = 1'b1;
    icache_rdata1 = d1;
    icache_rdata2 = d2;
    step();
    icache_rvalid = 1'b0;
  endtask

  task automatic chk_pkt(input string tag, input logic [31:0] p, input logic [31:0] i1,
                         input logic [31:0] i2, input logic [31:0] pr);
    chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
    chk({tag, "_pc1"}, pc1, p);
    chk({tag, "_pc2"}, pc2, p + 32'd4);
    chk({tag, "_inst1"}, inst1, i1);
    chk({tag, "_inst2"}, inst2, i2);
    chk({tag, "_pred"}, pred_addr, pr);
    chk({tag, "_exc"}, {31'd0, is_exception}, 32'd0);
    chk({tag, "_cause"}, {25'd0, exception_cause}, 32'd0);
  endtask

  logic [31:0] exp_pred5;
  logic        activity;

  initial begin
    rst = 1'b0; flush = 1'b0; flush_pc = '0; stall = 1'b0;
    icache_ready = 1'b0; icache_rvalid = 1'b0; icache_rdata1 = '0; icache_rdata2 = '0;
`ifdef BPRED_EN
    bp_taken = 1'b0; bp_target = '0;
    exp_pred5 = 32'h1c00_0400;
`else
    exp_pred5 = 32'h1c00_0018;
`endif
    step(); step();
    chk("rst_req", {31'd0, icache_req}, 32'd0);
    chk("rst_addr", icache_addr, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_pc1", pc1, 32'd0);
    chk("rst_pc2", pc2, 32'd0);
    chk("rst_pred", pred_addr, 32'd0);
    chk("rst_cause", {25'd0, exception_cause}, 32'd0);
    rst = 1'b1;
    step();

    // 1: first fetch after reset
    accept_req("t1", 32'h1c00_0000);
    respond(32'h1111_1111, 32'h2222_2222);
    chk_pkt("t1_pkt", 32'h1c00_0000, 32'h1111_1111, 32'h2222_2222, 32'h1c00_0008);
    step();
    chk("t1_one_shot", {31'd0, inst_valid}, 32'd0);

    // 2: stall on the response cycle, held across three edges
    accept_req("t2", 32'h1c00_0008);
    stall = 1'b1;
    respond(32'h3333_3333, 32'h4444_4444);
    chk("t2_hold0", {31'd0, inst_valid}, 32'd0);
    step();
    chk("t2_hold1", {31'd0, inst_valid}, 32'd0);
    step();
    chk("t2_hold2", {31'd0, inst_valid}, 32'd0);
    chk("t2_noreq", {31'd0, icache_req}, 32'd0);
    stall = 1'b0;
    step();
    chk_pkt("t2_pkt", 32'h1c00_0008, 32'h3333_3333, 32'h4444_4444, 32'h1c00_0010);
    step();
    chk("t2_nodup", {31'd0, inst_valid}, 32'd0);

    // 5: predictor hint on the response
    accept_req("t5", 32'h1c00_0010);
`ifdef BPRED_EN
    bp_taken = 1'b1; bp_target = 32'h1c00_0400;
`endif
    respond(32'h5555_5555, 32'h6666_6666);
`ifdef BPRED_EN
    bp_taken = 1'b0;
`endif
    chk_pkt("t5_pkt", 32'h1c00_0010, 32'h5555_5555, 32'h6666_6666, exp_pred5);
    step();

    // 3: flush while waiting; the stale response is dropped
    accept_req("t3", exp_pred5);
    flush = 1'b1; flush_pc = 32'h1c00_0100;
    step();
    flush = 1'b0;
    chk("t3_valid_after_flush", {31'd0, inst_valid}, 32'd0);
    chk("t3_req_blocked", {31'd0, icache_req}, 32'd0);
    respond(32'hdead_beef, 32'hdead_beef);
    chk("t3_stale_dropped", {31'd0, inst_valid}, 32'd0);
    chk("t3_req_after_drop", {31'd0, icache_req}, 32'd1);
    accept_req("t3b", 32'h1c00_0100);
    respond(32'h7777_7777, 32'h8888_8888);
    chk_pkt("t3_pkt", 32'h1c00_0100, 32'h7777_7777, 32'h8888_8888, 32'h1c00_0108);
    step();

    // flush coinciding with rvalid: flush wins, nothing owed afterwards
    accept_req("tf", 32'h1c00_0108);
    flush = 1'b1; flush_pc = 32'h1c00_0180;
    respond(32'h9999_9999, 32'h9999_9999);
    flush = 1'b0;
    chk("tf_valid", {31'd0, inst_valid}, 32'd0);
    chk("tf_req_now", {31'd0, icache_req}, 32'd1);
    chk("tf_addr", icache_addr, 32'h1c00_0180);

    // 6: wrap-around
    flush = 1'b1; flush_pc = 32'hffff_fff8;
    step();
    flush = 1'b0;
    accept_req("t6", 32'hffff_fff8);
    respond(32'haaaa_aaaa, 32'hbbbb_bbbb);
    chk_pkt("t6_pkt", 32'hffff_fff8, 32'haaaa_aaaa, 32'hbbbb_bbbb, 32'h0000_0000);
    step();
    accept_req("t6b", 32'h0000_0000);
    respond(32'hcccc_cccc, 32'hdddd_dddd);
    chk_pkt("t6b_pkt", 32'h0000_0000, 32'hcccc_cccc, 32'hdddd_dddd, 32'h0000_0008);

    // 4: misaligned redirect, emission gated by stall
    flush = 1'b1; flush_pc = 32'h1c00_0102; stall = 1'b1;
    step();
    flush = 1'b0;
    chk("t4_noreq", {31'd0, icache_req}, 32'd0);
    chk("t4_stalled0", {31'd0, inst_valid}, 32'd0);
    step();
    chk("t4_stalled1", {31'd0, inst_valid}, 32'd0);
    stall = 1'b0;
    step();
    chk("t4_valid", {31'd0, inst_valid}, 32'd1);
    chk("t4_exc", {31'd0, is_exception}, 32'd1);
    chk("t4_cause", {25'd0, exception_cause}, 32'h08);
    chk("t4_pc1", pc1, 32'h1c00_0102);
    chk("t4_inst1", inst1, 32'd0);
    chk("t4_inst2", inst2, 32'd0);
    activity = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      activity = activity | icache_req | inst_valid;
    end
    chk("t4_idle_in_exc", {31'd0, activity}, 32'd0);
    flush = 1'b1; flush_pc = 32'h1c00_0200;
    step();
    flush = 1'b0;
    accept_req("t4b", 32'h1c00_0200);
    respond(32'h1234_5678, 32'h9abc_def0);
    chk_pkt("t4b_pkt", 32'h1c00_0200, 32'h1234_5678, 32'h9abc_def0, 32'h1c00_0208);
    step();

    // asynchronous reset mid-transaction
    accept_req("tr", 32'h1c00_0208);
    #2;
    rst = 1'b0;
    #1;
    chk("tr_req", {31'd0, icache_req}, 32'd0);
    chk("tr_pc1", pc1, 32'd0);
    step();
    rst = 1'b1;
    step();
    accept_req("tr_restart", 32'h1c00_0000);
    respond(32'h0bad_f00d, 32'h0000_0001);
    chk_pkt("tr_pkt", 32'h1c00_0000, 32'h0bad_f00d, 32'h0000_0001, 32'h1c00_0008);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
